oam_dma_unit: RTL and testbench

- Sits directly downstream of NesCpu on the CPU bus, between the CPU and the memory/PPU decode.
- Passes CPU bus traffic through unchanged while idle.
- A CPU write to $4014 triggers the sprite DMA:
  - stalls the CPU;
  - copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port ($2004);
  - releases the CPU after 513 or 514 CPU cycles.
- Timing is driven by a one-cycle CPU clock-enable derived from the 21.47727 MHz master clock (divide by 12).

---
 rtl/oam_dma_unit.sv | 137 +++++++++++++
 tb/tb_oam_dma_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_unit.sv
// Sprite DMA between NesCpu and bus decode: a $4014 write stalls the CPU and copies one page to OAM ($2004).
// Optional macro OAM_DMA_CYCLE_COUNT_EN adds the dma_cycles output counting halted CPU cycles.
module oam_dma_unit #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_dataOut,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_dataIn,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_dataOut,
  output logic        bus_rw,
  output logic        cpu_halt,
  output logic        dma_active
`ifdef OAM_DMA_CYCLE_COUNT_EN
  ,
  output logic [9:0]  dma_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] buffer_q, buffer_d;
  logic       odd_q;
  logic       start;

  assign start = (state_q == S_IDLE) && !cpu_rw && (cpu_address == DMA_REG_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      buffer_q <= 8'h00;
      odd_q    <= 1'b0;
    end else if (cpu_ce) begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      buffer_q <= buffer_d;
      odd_q    <= ~odd_q;
    end
  end

  // Next state is only committed on cpu_ce, so this block assumes a CPU cycle boundary.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    buffer_d = buffer_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          page_d  = cpu_dataOut;
          index_d = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // Reads must land on even cycles; an even HALT needs one extra dummy cycle.
        state_d = odd_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        buffer_d = bus_dataIn;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (index_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          index_d = index_q + 8'h01;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_address = cpu_address;
    bus_dataOut = cpu_dataOut;
    bus_rw      = cpu_rw;
    case (state_q)
      S_HALT, S_ALIGN: begin
        bus_rw = 1'b1;
      end
      S_READ: begin
        bus_address = {page_q, index_q};
        bus_rw      = 1'b1;
      end
      S_WRITE: begin
        bus_address = OAM_DATA_ADDR;
        bus_dataOut = buffer_q;
        bus_rw      = 1'b0;
      end
      default: ;
    endcase
  end

  assign dma_active = (state_q != S_IDLE);
  assign cpu_halt   = dma_active;

`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0] cycles_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles_q <= 10'd0;
    end else if (cpu_ce) begin
      if (start) begin
        cycles_q <= 10'd0;
      end else if (dma_active) begin
        cycles_q <= cycles_q + 10'd1;
      end
    end
  end

  assign dma_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_oam_dma_unit.sv
// Self-checking bench for oam_dma_unit: passthrough vector table plus a queue-based transfer model.
module tb_oam_dma_unit;
  localparam int GAP = 3;

  logic        clock;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_dataOut;
  logic        cpu_rw;
  logic [7:0]  bus_dataIn;
  logic [15:0] bus_address;
  logic [7:0]  bus_dataOut;
  logic        bus_rw;
  logic        cpu_halt;
  logic        dma_active;
  logic [7:0]  mem_xor;
`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0]  dma_cycles;
`endif

  oam_dma_unit dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_ce     (cpu_ce),
    .cpu_address(cpu_address),
    .cpu_dataOut(cpu_dataOut),
    .cpu_rw     (cpu_rw),
    .bus_dataIn (bus_dataIn),
    .bus_address(bus_address),
    .bus_dataOut(bus_dataOut),
    .bus_rw     (bus_rw),
    .cpu_halt   (cpu_halt),
    .dma_active (dma_active)
`ifdef OAM_DMA_CYCLE_COUNT_EN
    ,
    .dma_cycles (dma_cycles)
`endif
  );

  // Memory returns the low address byte, optionally scrambled by mem_xor.
  assign bus_dataIn = bus_address[7:0] ^ mem_xor;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          kind;   // 0 dummy halt cycle, 1 source read, 2 OAM write
    logic [15:0] addr;
    logic [7:0]  data;
  } op_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_rw;
    logic        exp_halt;
  } vec_t;

  op_t  exp_q[$];
  int   checks;
  int   errors;
  bit   model_odd;
  int   exp_len;
  logic last_halt;
  int   halted;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    op_t e;
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("halt_busy", {15'd0, cpu_halt}, 16'd1);
      chk("active_busy", {15'd0, dma_active}, 16'd1);
      case (e.kind)
        0: begin
          chk("dummy_addr", bus_address, cpu_address);
          chk("dummy_rw", {15'd0, bus_rw}, 16'd1);
`ifdef OAM_DMA_CYCLE_COUNT_EN
          if (exp_q.size() == exp_len) chk("cycles_cleared", {6'd0, dma_cycles}, 16'd0);
`endif
        end
        1: begin
          chk("read_addr", bus_address, e.addr);
          chk("read_rw", {15'd0, bus_rw}, 16'd1);
        end
        default: begin
          chk("write_addr", bus_address, 16'h2004);
          chk("write_rw", {15'd0, bus_rw}, 16'd0);
          chk("write_data", {8'd0, bus_dataOut}, {8'd0, e.data});
        end
      endcase
    end else begin
      chk("halt_idle", {15'd0, cpu_halt}, 16'd0);
      chk("active_idle", {15'd0, dma_active}, 16'd0);
      chk("pass_addr", bus_address, cpu_address);
      chk("pass_data", {8'd0, bus_dataOut}, {8'd0, cpu_dataOut});
      chk("pass_rw", {15'd0, bus_rw}, {15'd0, cpu_rw});
    end
  endtask

  task automatic build(input logic [7:0] page, input bit odd_now);
    op_t e;
    logic [15:0] src;
    int nd;
    nd = odd_now ? 2 : 1;
    for (int i = 0; i < nd; i++) begin
      e.kind = 0; e.addr = 16'h0000; e.data = 8'h00;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 256; k++) begin
      src = {page, 8'(k)};
      e.kind = 1; e.addr = src; e.data = 8'h00;
      exp_q.push_back(e);
      e.kind = 2; e.addr = 16'h2004; e.data = src[7:0] ^ mem_xor;
      exp_q.push_back(e);
    end
    exp_len = nd + 512;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bit was_busy;
    cpu_address = a;
    cpu_dataOut = d;
    cpu_rw      = rw;
    for (int g = 0; g < GAP; g++) begin
      @(negedge clock);
      check_outputs();
    end
    last_halt = cpu_halt;
    cpu_ce = 1'b1;
    @(negedge clock);
    cpu_ce = 1'b0;
    was_busy = (exp_q.size() != 0);
    if (was_busy) void'(exp_q.pop_front());
    else if (!rw && a == 16'h4014) build(d, model_odd);
    model_odd = ~model_odd;
  endtask

  task automatic busy_cycle();
    logic [15:0] a;
    a = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
    cpu_cycle(a, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic idle_cycle();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    cpu_cycle(a, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic start_transfer(input logic [7:0] page, input bit want_odd);
    if (model_odd != want_odd) idle_cycle();
    cpu_cycle(16'h4014, page, 1'b0);
  endtask

  task automatic finish_transfer(input int exp_halted);
    int n;
    n = 0;
    halted = 0;
    while (exp_q.size() != 0 && n < 600) begin
      busy_cycle();
      if (last_halt === 1'b1) halted++;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL transfer_timeout: %0d ops left after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    chk("halted_cycles", 16'(halted), 16'(exp_halted));
    idle_cycle();
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("dma_cycles_final", {6'd0, dma_cycles}, 16'(exp_halted));
`endif
  endtask

  vec_t vecs[6];

  initial begin
    checks = 0; errors = 0; model_odd = 1'b0; exp_len = 0; last_halt = 1'b0; halted = 0;
    mem_xor = 8'h00;
    reset = 1'b0; cpu_ce = 1'b0;
    cpu_address = 16'h8000; cpu_dataOut = 8'h11; cpu_rw = 1'b1;

    vecs[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16'h0300, 8'h5A, 1'b0, 16'h0300, 8'h5A, 1'b0, 1'b0};
    vecs[2] = '{16'h4014, 8'h07, 1'b1, 16'h4014, 8'h07, 1'b1, 1'b0};
    vecs[3] = '{16'h4015, 8'h07, 1'b0, 16'h4015, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{16'h2004, 8'hC3, 1'b0, 16'h2004, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFC, 8'hA5, 1'b1, 16'hFFFC, 8'hA5, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_halt", {15'd0, cpu_halt}, 16'd0);
    chk("rst_active", {15'd0, dma_active}, 16'd0);
    chk("rst_addr", bus_address, 16'h8000);
    chk("rst_rw", {15'd0, bus_rw}, 16'd1);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("rst_cycles", {6'd0, dma_cycles}, 16'd0);
`endif
    reset = 1'b1;
    @(negedge clock);

    // Idle passthrough table
    for (int i = 0; i < 6; i++) begin
      cpu_cycle(vecs[i].a, vecs[i].d, vecs[i].rw);
      chk("vec_addr", bus_address, vecs[i].exp_addr);
      chk("vec_data", {8'd0, bus_dataOut}, {8'd0, vecs[i].exp_data});
      chk("vec_rw", {15'd0, bus_rw}, {15'd0, vecs[i].exp_rw});
      chk("vec_halt", {15'd0, cpu_halt}, {15'd0, vecs[i].exp_halt});
    end

    // Even-parity start, then odd-parity start, then last page
    start_transfer(8'h02, 1'b0);
    finish_transfer(513);
    start_transfer(8'h02, 1'b1);
    finish_transfer(514);
    start_transfer(8'hFF, 1'b0);
    finish_transfer(513);

    // Reset mid-transfer at index 0x40
    start_transfer(8'h03, 1'b1);
    for (int n = 0; n < 400; n++) begin
      if (exp_q.size() != 0 && exp_q[0].kind == 1 && exp_q[0].addr[7:0] == 8'h40) break;
      busy_cycle();
    end
    cpu_address = 16'h1234; cpu_dataOut = 8'h99; cpu_rw = 1'b1;
    @(negedge clock);
    chk("pre_rst_halt", {15'd0, cpu_halt}, 16'd1);
    chk("pre_rst_addr", bus_address, 16'h0340);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_halt", {15'd0, cpu_halt}, 16'd0);
    chk("mid_rst_active", {15'd0, dma_active}, 16'd0);
    chk("mid_rst_addr", bus_address, 16'h1234);
    chk("mid_rst_rw", {15'd0, bus_rw}, 16'd1);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("mid_rst_cycles", {6'd0, dma_cycles}, 16'd0);
`endif
    exp_q.delete();
    model_odd = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    start_transfer(8'h05, 1'b0);
    finish_transfer(513);

    // Randomized transfers against the model
    for (int r = 0; r < 3; r++) begin
      bit par;
      mem_xor = 8'($urandom);
      repeat ($urandom_range(1, 5)) idle_cycle();
      par = 1'($urandom_range(0, 1));
      start_transfer(8'($urandom), par);
      finish_transfer(par ? 514 : 513);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
